// File: rtl/alu_issue_ctrl.sv
// Issue controller that registers one ALU request, waits one execute cycle and
// holds the captured result until the consumer takes it. Optional counters: ALU_ISSUE_CNT_EN.
module alu_issue_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [31:0] req_src1_i,
  input  logic [31:0] req_src2_i,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic        alu_invertA_o,
  output logic        alu_invertB_o,
  output logic [1:0]  alu_operation_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  input  logic        alu_overflow_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_overflow_o,
  output logic        rsp_illegal_o,
`ifdef ALU_ISSUE_CNT_EN
  output logic [15:0] issue_cnt_o,
  output logic [15:0] ovf_cnt_o,
`endif
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid must not depend on ready, and payload is held while valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        rdy_en_q, rdy_en_d;
  logic [31:0] alu_src1_q, alu_src1_d;
  logic [31:0] alu_src2_q, alu_src2_d;
  logic        alu_inv_a_q, alu_inv_a_d;
  logic        alu_inv_b_q, alu_inv_b_d;
  logic [1:0]  alu_oper_q, alu_oper_d;
  logic        arith_q, arith_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_ill_q, rsp_ill_d;

  logic        dec_legal, dec_inv_a, dec_inv_b, dec_arith;
  logic [1:0]  dec_oper;
  logic        accept;

  always_comb begin
    dec_legal = 1'b1;
    dec_inv_a = 1'b0;
    dec_inv_b = 1'b0;
    dec_oper  = 2'b00;
    dec_arith = 1'b0;
    case (req_op_i)
      4'b0000: dec_oper = 2'b00;
      4'b0001: dec_oper = 2'b01;
      4'b0010: begin dec_oper = 2'b10; dec_arith = 1'b1; end
      4'b0110: begin dec_oper = 2'b10; dec_inv_b = 1'b1; dec_arith = 1'b1; end
      4'b1100: begin dec_oper = 2'b00; dec_inv_a = 1'b1; dec_inv_b = 1'b1; end
      4'b0111: begin dec_oper = 2'b11; dec_inv_b = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rdy_en_q     <= 1'b0;
      alu_src1_q   <= '0;
      alu_src2_q   <= '0;
      alu_inv_a_q  <= 1'b0;
      alu_inv_b_q  <= 1'b0;
      alu_oper_q   <= 2'b00;
      arith_q      <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_ill_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_en_q     <= rdy_en_d;
      alu_src1_q   <= alu_src1_d;
      alu_src2_q   <= alu_src2_d;
      alu_inv_a_q  <= alu_inv_a_d;
      alu_inv_b_q  <= alu_inv_b_d;
      alu_oper_q   <= alu_oper_d;
      arith_q      <= arith_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_ill_q    <= rsp_ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = dec_legal ? EXEC : RESP;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is held off until the first edge after reset release.
  always_comb begin
    rdy_en_d     = 1'b1;
    alu_src1_d   = alu_src1_q;
    alu_src2_d   = alu_src2_q;
    alu_inv_a_d  = alu_inv_a_q;
    alu_inv_b_d  = alu_inv_b_q;
    alu_oper_d   = alu_oper_q;
    arith_d      = arith_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_ill_d    = rsp_ill_q;
    if (accept && dec_legal) begin
      alu_src1_d  = req_src1_i;
      alu_src2_d  = req_src2_i;
      alu_inv_a_d = dec_inv_a;
      alu_inv_b_d = dec_inv_b;
      alu_oper_d  = dec_oper;
      arith_d     = dec_arith;
    end else if (accept) begin
      rsp_result_d = '0;
      rsp_zero_d   = 1'b0;
      rsp_ovf_d    = 1'b0;
      rsp_ill_d    = 1'b1;
    end else if (state_q == EXEC) begin
      rsp_result_d = alu_result_i;
      rsp_zero_d   = alu_zero_i;
      rsp_ovf_d    = alu_overflow_i & arith_q;
      rsp_ill_d    = 1'b0;
    end
  end

  always_comb begin
    req_ready_o = (state_q == IDLE) & rdy_en_q;
    rsp_valid_o = (state_q == RESP);
    dbg_state_o = state_q;
  end

  assign alu_src1_o      = alu_src1_q;
  assign alu_src2_o      = alu_src2_q;
  assign alu_invertA_o   = alu_inv_a_q;
  assign alu_invertB_o   = alu_inv_b_q;
  assign alu_operation_o = alu_oper_q;
  assign rsp_result_o    = rsp_result_q;
  assign rsp_zero_o      = rsp_zero_q;
  assign rsp_overflow_o  = rsp_ovf_q;
  assign rsp_illegal_o   = rsp_ill_q;

`ifdef ALU_ISSUE_CNT_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Overflow is counted once per response, at the edge it is captured.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    ovf_cnt_d   = ovf_cnt_q;
    if (accept && dec_legal) issue_cnt_d = issue_cnt_q + 16'd1;
    if (state_q == EXEC && alu_overflow_i && arith_q) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_cnt_q <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign issue_cnt_o = issue_cnt_q;
  assign ovf_cnt_o   = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; a small behavioural ALU closes the loop
// from alu_* outputs back to alu_result_i / alu_zero_i / alu_overflow_i.
module tb_alu_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_op_i;
  logic [31:0] req_src1_i, req_src2_i;
  logic [31:0] alu_src1_o, alu_src2_o;
  logic        alu_invertA_o, alu_invertB_o;
  logic [1:0]  alu_operation_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i, alu_overflow_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o, rsp_overflow_o, rsp_illegal_o;
  logic [1:0]  dbg_state_o;
`ifdef ALU_ISSUE_CNT_EN
  logic [15:0] issue_cnt_o, ovf_cnt_o;
`endif

  int tests = 0;
  int fails = 0;

  alu_issue_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_src1_i(req_src1_i), .req_src2_i(req_src2_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_invertA_o(alu_invertA_o), .alu_invertB_o(alu_invertB_o),
    .alu_operation_o(alu_operation_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .alu_overflow_i(alu_overflow_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_zero_o(rsp_zero_o), .rsp_overflow_o(rsp_overflow_o), .rsp_illegal_o(rsp_illegal_o),
`ifdef ALU_ISSUE_CNT_EN
    .issue_cnt_o(issue_cnt_o), .ovf_cnt_o(ovf_cnt_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // External ALU: adder overflow is reported for both the add and SLT paths.
  logic [31:0] m_a, m_b, m_sum;
  logic        m_ovf;
  always_comb begin
    m_a   = alu_invertA_o ? ~alu_src1_o : alu_src1_o;
    m_b   = alu_invertB_o ? ~alu_src2_o : alu_src2_o;
    m_sum = m_a + m_b + {31'b0, alu_invertB_o};
    m_ovf = (m_a[31] == m_b[31]) && (m_sum[31] != m_a[31]);
    case (alu_operation_o)
      2'b00:   alu_result_i = m_a & m_b;
      2'b01:   alu_result_i = m_a | m_b;
      2'b10:   alu_result_i = m_sum;
      default: alu_result_i = {31'b0, m_sum[31] ^ m_ovf};
    endcase
    alu_zero_i     = (alu_result_i == 32'h0);
    alu_overflow_i = alu_operation_o[1] & m_ovf;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request for exactly one edge; returns 1 time unit after it.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_src1_i  = a;
    req_src2_i  = b;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] res, input logic z,
                           input logic o, input logic ill);
    check({tag, ".valid"}, rsp_valid_o, 1'b1);
    check({tag, ".result"}, rsp_result_o, res);
    check({tag, ".zero"}, rsp_zero_o, z);
    check({tag, ".ovf"}, rsp_overflow_o, o);
    check({tag, ".illegal"}, rsp_illegal_o, ill);
    check({tag, ".ready_low"}, req_ready_o, 1'b0);
  endtask

  // Legal op: EXEC after accept edge N, response after N+1, idle after N+2 (rsp_ready_i=1).
  task automatic run_legal(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic z,
                           input logic o);
    issue(op, a, b);
    check({tag, ".exec_state"}, dbg_state_o, 2'd1);
    check({tag, ".exec_novalid"}, rsp_valid_o, 1'b0);
    check({tag, ".src1"}, alu_src1_o, a);
    check({tag, ".src2"}, alu_src2_o, b);
    step();
    check_rsp(tag, res, z, o, 1'b0);
    step();
    check({tag, ".done_novalid"}, rsp_valid_o, 1'b0);
    check({tag, ".done_ready"}, req_ready_o, 1'b1);
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_op_i    = 4'h0;
    req_src1_i  = '0;
    req_src2_i  = '0;
    rsp_ready_i = 1'b0;

    repeat (2) step();
    check("rst.ready", req_ready_o, 1'b0);
    check("rst.valid", rsp_valid_o, 1'b0);
    check("rst.result", rsp_result_o, 32'h0);
    check("rst.src1", alu_src1_o, 32'h0);
    check("rst.oper", alu_operation_o, 2'b00);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst.ready_before_edge", req_ready_o, 1'b0);
    step();
    check("rst.ready_after_edge", req_ready_o, 1'b1);
    check("rst.state", dbg_state_o, 2'd0);

    rsp_ready_i = 1'b1;
    // ADD overflow: controls checked while in EXEC by run_legal's neighbours below.
    run_legal("add", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);

    issue(4'b0110, 32'h5, 32'h5);
    check("sub.invA", alu_invertA_o, 1'b0);
    check("sub.invB", alu_invertB_o, 1'b1);
    check("sub.oper", alu_operation_o, 2'b10);
    step();
    check_rsp("sub", 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    check("sub.done", rsp_valid_o, 1'b0);

    run_legal("slt", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1, 1'b0, 1'b0);
    // ALU reports overflow on this SLT; the response must not.
    run_legal("slt_ovf", 4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h1, 1'b0, 1'b0);

    issue(4'b1100, 32'h0F0F_0F0F, 32'h00FF_00FF);
    check("nor.invA", alu_invertA_o, 1'b1);
    check("nor.invB", alu_invertB_o, 1'b1);
    check("nor.oper", alu_operation_o, 2'b00);
    step();
    check_rsp("nor", 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    step();

    // Illegal op: response right after accept edge, ALU controls untouched.
    issue(4'b0011, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    check_rsp("ill", 32'h0, 1'b0, 1'b0, 1'b1);
    check("ill.src1", alu_src1_o, 32'h0F0F_0F0F);
    check("ill.src2", alu_src2_o, 32'h00FF_00FF);
    check("ill.invA", alu_invertA_o, 1'b1);
    check("ill.oper", alu_operation_o, 2'b00);
    step();
    check("ill.done", rsp_valid_o, 1'b0);

    run_legal("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0);

    // Backpressure: hold the response for 5 edges, with a stray request on the way.
    rsp_ready_i = 1'b0;
    issue(4'b0001, 32'h1234_0000, 32'h0000_5678);
    step();
    for (int i = 0; i < 5; i++) begin
      check_rsp("bp", 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      check("bp.src1", alu_src1_o, 32'h1234_0000);
      if (i == 1) begin
        req_valid_i = 1'b1;
        req_op_i    = 4'b0010;
        req_src1_i  = 32'hAAAA_AAAA;
        req_src2_i  = 32'h5555_5555;
      end
      step();
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    step();
    check("bp.release_valid", rsp_valid_o, 1'b0);
    check("bp.release_ready", req_ready_o, 1'b1);
    check("bp.release_state", dbg_state_o, 2'd0);
    check("bp.src1_kept", alu_src1_o, 32'h1234_0000);
`ifdef ALU_ISSUE_CNT_EN
    check("cnt.issue", issue_cnt_o, 32'd7);
    check("cnt.ovf", ovf_cnt_o, 32'd1);
`endif

    // Reset pulse while in EXEC drops the request.
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
    check("mid.exec", dbg_state_o, 2'd1);
    rst_i = 1'b1;
    #1;
    check("mid.rst_valid", rsp_valid_o, 1'b0);
    check("mid.rst_ready", req_ready_o, 1'b0);
    check("mid.rst_src1", alu_src1_o, 32'h0);
    check("mid.rst_ill", rsp_illegal_o, 1'b0);
    check("mid.rst_result", rsp_result_o, 32'h0);
    #2;
    rst_i = 1'b0;
    #1;
    check("mid.ready_before_edge", req_ready_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid.no_valid", rsp_valid_o, 1'b0);
      check("mid.ready", req_ready_o, 1'b1);
      check("mid.result", rsp_result_o, 32'h0);
    end
`ifdef ALU_ISSUE_CNT_EN
    check("cnt.rst_issue", issue_cnt_o, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
